adc_frame_capture: RTL

// Write side of the ADC sample buffer that feeds the smoothing filter. Once armed, it accepts
// 8-bit ADC samples over a valid/ready stream and stores LEN of them in a DEPTH-entry RAM.
// It then signals that a full frame is ready and serves random-access reads to the filter.
// The frame is held until the filter acknowledges it; samples arriving outside capture are counted as dropped.

---
 rtl/adc_frame_capture_if.sv | 44 ++++
 rtl/adc_frame_capture.sv | 137 +++++++++++++
 2 files changed

// File: rtl/adc_frame_capture_if.sv
`timescale 1ns/1ps
// adc_frame_capture_if
// Groups the sample stream, frame handshake, random-access read port and
// status counters of the ADC frame capture buffer.
//   arm         request a new frame capture
//   s_valid     ADC sample valid
//   s_data      ADC sample
//   s_ready     buffer accepts a sample this cycle
//   frame_done  one-cycle pulse when a frame of LEN samples is complete
//   frame_ready level, frame is held and readable
//   frame_ack   consumer finished with the frame
//   rd_en       read request
//   rd_addr     read address
//   rd_data     read data, valid one cycle after rd_en
//   wr_count    samples written in the current frame
//   drop_count  saturating count of samples offered while not ready
// master = producer/consumer side, slave = the capture buffer.
interface adc_frame_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) ();
    logic              arm;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              frame_done;
    logic              frame_ready;
    logic              frame_ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   wr_count;
    logic [15:0]       drop_count;

    modport master (
        output arm, s_valid, s_data, frame_ack, rd_en, rd_addr,
        input  s_ready, frame_done, frame_ready, rd_data, wr_count, drop_count
    );

    modport slave (
        input  arm, s_valid, s_data, frame_ack, rd_en, rd_addr,
        output s_ready, frame_done, frame_ready, rd_data, wr_count, drop_count
    );
endinterface

// File: rtl/adc_frame_capture.sv
`timescale 1ns/1ps
// adc_frame_capture
// Write side of the ADC sample buffer feeding the smoothing filter. When
// armed it accepts LEN samples over a valid/ready stream into a DEPTH-entry
// RAM, flags the completed frame and holds it until the filter acknowledges
// it. Random-access reads are served at any time with one cycle of latency.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  adc_frame_capture_if.slave (stream, frame handshake, read port,
//        wr_count / drop_count status)
module adc_frame_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int LEN    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_frame_capture_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LEN_C  = (ADDR_W+1)'(LEN);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   wr_count;
    logic [ADDR_W:0]   wr_count_next;
    logic              frame_done_p1;
    logic              frame_done_next;
    logic [15:0]       drop_count;
    logic [DATA_W-1:0] rd_data_p1;
    logic              s_ready_int;
    logic              transfer;
    logic              last_xfer;

    logic [DATA_W-1:0] mem [DEPTH];

    assign s_ready_int = (state == CAPTURE);
    assign transfer    = bus.s_valid & s_ready_int;
    assign last_xfer   = transfer && (wr_count == LAST_C);

    // State register and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_count      <= '0;
            frame_done_p1 <= 1'b0;
        end else begin
            state         <= state_next;
            wr_count      <= wr_count_next;
            frame_done_p1 <= frame_done_next;
        end
    end

    // Next-state logic. Every entry into CAPTURE restarts the frame at
    // address 0; an ack that also carries arm skips IDLE entirely.
    always_comb begin
        state_next      = state;
        wr_count_next   = wr_count;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.arm) begin
                    state_next    = CAPTURE;
                    wr_count_next = '0;
                end
            end
            CAPTURE: begin
                if (transfer) begin
                    wr_count_next = wr_count + 1'b1;
                    if (last_xfer) begin
                        state_next      = DONE;
                        frame_done_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.frame_ack) begin
                    state_next    = bus.arm ? CAPTURE : IDLE;
                    wr_count_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                wr_count_next = '0;
            end
        endcase
    end

    // Offered-but-refused samples, saturating so a stalled filter cannot wrap it
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (bus.s_valid && !s_ready_int && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Sample RAM, not reset. wr_count stays below LEN while transfers occur,
    // so its low bits are a valid RAM address.
    always_ff @(posedge clk) begin
        if (transfer) begin
            mem[wr_count[ADDR_W-1:0]] <= bus.s_data;
        end
    end

    // Read stage: registered output, holds when idle. Addresses past the
    // frame read as zero so the filter window can overrun the frame end.
    // The non-blocking RAM write gives read-before-write on address clashes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (bus.rd_en) begin
            if ({1'b0, bus.rd_addr} >= LEN_C) begin
                rd_data_p1 <= '0;
            end else begin
                rd_data_p1 <= mem[bus.rd_addr];
            end
        end
    end

    assign bus.s_ready     = s_ready_int;
    assign bus.frame_done  = frame_done_p1;
    assign bus.frame_ready = (state == DONE);
    assign bus.rd_data     = rd_data_p1;
    assign bus.wr_count    = wr_count;
    assign bus.drop_count  = drop_count;

endmodule
